// File: rtl/average_pkg.sv
// Shared defaults and state type for the moving-average block.
package average_pkg;

  localparam int WINDOW_LOG2_DEF = 32'd7;
  localparam int DATA_W_DEF      = 32'd32;
  localparam int SUM_W_DEF       = DATA_W_DEF + WINDOW_LOG2_DEF;

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } fill_state_e;

endpackage

// File: rtl/average_window_buf.sv
// Circular sample buffer with write pointer and combinational read of the
// oldest entry (the slot about to be overwritten).
module average_window_buf
  import average_pkg::*;
#(
  parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] oldest
);

  localparam int N = 1 << WINDOW_LOG2;
  localparam logic [WINDOW_LOG2-1:0] PTR_ONE = WINDOW_LOG2'(1);

  logic [DATA_W-1:0]      mem_r [N];
  logic [WINDOW_LOG2-1:0] wp_r;

  // Sample storage; contents need no reset since stale slots are never read
  // into the sum before being overwritten.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wp_r] <= wdata;
    end
  end

  // Write pointer wraps naturally at N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_r <= '0;
    end else if (we) begin
      wp_r <= wp_r + PTR_ONE;
    end
  end

  assign oldest = mem_r[wp_r];

endmodule

// File: rtl/average.sv
// Streaming moving average over the last 2^WINDOW_LOG2 samples; pulses
// averageReady with the floor mean for every sample once the window is full.
module average
  import average_pkg::*;
#(
  parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              addValue,
  input  logic [DATA_W-1:0] inputData,
  output logic              averageReady,
  output logic [DATA_W-1:0] outputData
);

  localparam int SUM_W = DATA_W + WINDOW_LOG2;
  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << WINDOW_LOG2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fill_state_e       state_r, next_state_s;
  logic [SUM_W-1:0]  sum_r, next_sum_s;
  logic [CNT_W-1:0]  cnt_r, next_cnt_s;
  logic [DATA_W-1:0] oldest_s;
  logic              load_s;

  average_window_buf #(
    .WINDOW_LOG2(WINDOW_LOG2),
    .DATA_W     (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst   (n_rst),
    .we    (addValue),
    .wdata (inputData),
    .oldest(oldest_s)
  );

  // Next-state, running-sum and fill-count update for the accepted sample.
  always_comb begin
    next_state_s = state_r;
    next_sum_s   = sum_r;
    next_cnt_s   = cnt_r;
    load_s       = 1'b0;
    if (addValue) begin
      case (state_r)
        FILLING: begin
          next_sum_s = sum_r + SUM_W'(inputData);
          next_cnt_s = cnt_r + CNT_ONE;
        end
        FULL: begin
          // Oldest sample is read before the buffer overwrites it this edge.
          next_sum_s = sum_r + SUM_W'(inputData) - SUM_W'(oldest_s);
        end
        default: begin
          next_state_s = FILLING;
        end
      endcase
      if (next_cnt_s == CNT_FULL) begin
        load_s       = 1'b1;
        next_state_s = FULL;
      end else begin
        load_s       = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // FSM, sum and fill-count registers.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r <= FILLING;
      sum_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      sum_r   <= next_sum_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Registered outputs; the mean holds between pulses.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      averageReady <= 1'b0;
      outputData   <= '0;
    end else begin
      averageReady <= load_s;
      if (load_s) begin
        outputData <= DATA_W'(next_sum_s >> WINDOW_LOG2);
      end
    end
  end

endmodule

// File: tb/tb_average.sv
// Self-checking bench for average: directed scenarios plus random samples,
// checked against a queue-based window model.
module tb_average;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        addValue;
  logic [31:0] inputData;
  logic        averageReady;
  logic [31:0] outputData;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] win[$];
  logic        exp_ready;
  logic [31:0] exp_out;

  average dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .addValue    (addValue),
    .inputData   (inputData),
    .averageReady(averageReady),
    .outputData  (outputData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: the window is simply the last N accepted samples.
  task automatic model_push(input logic [31:0] d);
    longint unsigned s;
    win.push_back(d);
    if (win.size() > N) void'(win.pop_front());
    if (win.size() == N) begin
      s = 0;
      foreach (win[i]) s += longint'(win[i]);
      exp_out   = 32'(s / N);
      exp_ready = 1'b1;
    end else begin
      exp_ready = 1'b0;
    end
  endtask

  task automatic step(input logic av, input logic [31:0] d);
    @(negedge clk);
    addValue  = av;
    inputData = d;
    @(posedge clk);
    #1;
    if (av) model_push(d);
    else exp_ready = 1'b0;
    chk("ready", {31'd0, averageReady}, {31'd0, exp_ready});
    chk("data", outputData, exp_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    addValue  = 1'b0;
    inputData = 32'd0;
    #2;
    n_rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, averageReady}, 32'd0);
    chk("async_rst_data", outputData, 32'd0);
    win.delete();
    exp_ready = 1'b0;
    exp_out   = 32'd0;
    @(negedge clk);
    n_rst = 1'b0;
  endtask

  initial begin
    n_rst     = 1'b1;
    addValue  = 1'b0;
    inputData = 32'd0;
    exp_ready = 1'b0;
    exp_out   = 32'd0;
    #1;
    chk("por_ready", {31'd0, averageReady}, 32'd0);
    chk("por_data", outputData, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, averageReady}, 32'd0);
    chk("rst_data", outputData, 32'd0);
    @(negedge clk);
    n_rst = 1'b0;
    repeat (5) step(1'b0, 32'd0);

    // Fill with spaced strobes
    for (int k = 1; k <= 135; k++) begin
      step(1'b1, (k <= 2) ? 32'd1 : 32'd54321);
      if (k == 128) chk("fill_128", outputData, 32'd53472);
      if (k == 129) chk("fill_129", outputData, 32'd53896);
      if (k >= 130) chk("fill_steady", outputData, 32'd54321);
      repeat (11) step(1'b0, 32'd0);
    end

    // Back-to-back all-ones, then zeros
    do_reset();
    repeat (N) step(1'b1, 32'hFFFF_FFFF);
    chk("b2b_max", outputData, 32'hFFFF_FFFF);
    repeat (20) step(1'b1, 32'd0);

    // Wrap-around with incrementing values
    do_reset();
    for (int v = 1; v <= 300; v++) begin
      step(1'b1, 32'(v));
      if (v == 128) chk("wrap_128", outputData, 32'd64);
      if (v == 300) chk("wrap_300", outputData, 32'd236);
    end

    // Mid-operation reset, refill with random gaps
    do_reset();
    repeat (200) step(1'b1, $urandom());
    do_reset();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 32'd0);
      step(1'b1, $urandom());
    end
    chk("refill_pulse", {31'd0, averageReady}, 32'd1);

    // Idle hold
    repeat (50) step(1'b0, $urandom());

    // Random mix of strobes and idles
    repeat (300) step(1'($urandom_range(0, 1)), $urandom());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
